key_fifo_ctrl: RTL and testbench

Sequencing controller for the dual-port keyboard character buffer RAM. It owns the write and read pointers, occupancy count, full/empty/overflow status and the CPU-side read handshake. Inputs are the keyboard decoder's char-write strobe and the memory-mapped I/O read request. It drives the RAM port addresses and enables; the RAM itself stays external. The whole block runs in the clk_50m domain.

---
 rtl/kbd_pkg.sv | 24 ++
 rtl/key_fifo_ctrl.sv | 139 +++++++++++++
 tb/tb_key_fifo_ctrl.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/kbd_pkg.sv
// ============================================================================
// kbd_pkg : shared constants and read-FSM encoding for the keyboard buffer
// Revision: 1.0
// ============================================================================
`default_nettype none

package kbd_pkg;

  localparam int ADDR_W_DEF = 14;
  localparam int DATA_W_DEF = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    ACK  = 2'd2
  } rd_state_t;

  localparam int STAT_EMPTY = 16;
  localparam int STAT_FULL  = 17;
  localparam int STAT_OVF   = 31;

endpackage

`default_nettype wire

// File: rtl/key_fifo_ctrl.sv
// ============================================================================
// key_fifo_ctrl : pointer/count/status sequencer and CPU read handshake for
//                 the external dual-port keyboard character RAM
// Revision: 1.0
// ============================================================================
`default_nettype none

module key_fifo_ctrl
  import kbd_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk_50m,
  input  logic              rstn,
  input  logic              push_valid,
  input  logic [DATA_W-1:0] push_data,
  input  logic              flush,
  input  logic              rd_req,
  input  logic              rd_sel,
  output logic              rd_ack,
  output logic [31:0]       rd_data,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_waddr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic [ADDR_W-1:0] ram_raddr,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              full,
  output logic              empty,
  output logic              overflow
);

  localparam int DEPTH = 2 ** ADDR_W;

  rd_state_t         state_q, state_d;
  logic [ADDR_W-1:0] wptr_q, rptr_q;
  logic [ADDR_W:0]   count_q;
  logic              ovf_q;
  logic [31:0]       rd_data_q, rd_data_d;
  logic [31:0]       status_word;
  logic              push_ok, push_drop, pop_done, ovf_clr;

  assign full  = (count_q == (ADDR_W+1)'(DEPTH));
  assign empty = (count_q == '0);
  assign overflow = ovf_q;

  // flush wins over both the write and the drop detection
  assign push_ok   = push_valid & ~full & ~flush;
  assign push_drop = push_valid &  full & ~flush;

  assign ram_we    = push_ok;
  assign ram_waddr = wptr_q;
  assign ram_wdata = push_data;
  assign ram_raddr = rptr_q;

  assign rd_ack  = (state_q == ACK);
  assign rd_data = rd_data_q;

  always_comb begin
    status_word                = '0;
    status_word[ADDR_W:0]      = count_q;
    status_word[STAT_EMPTY]    = empty;
    status_word[STAT_FULL]     = full;
    status_word[STAT_OVF]      = ovf_q;
  end

  always_comb begin
    state_d   = state_q;
    rd_data_d = rd_data_q;
    pop_done  = 1'b0;
    ovf_clr   = 1'b0;
    case (state_q)
      IDLE: begin
        if (rd_req) begin
          if (rd_sel) begin
            state_d   = ACK;
            rd_data_d = status_word;
            ovf_clr   = 1'b1;
          end else if (empty || flush) begin
            // nothing to pop (or buffer being cleared): answer immediately with 0
            state_d   = ACK;
            rd_data_d = '0;
          end else begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        state_d = ACK;
        if (flush) begin
          rd_data_d = '0;
        end else begin
          rd_data_d = {{(32-DATA_W){1'b0}}, ram_rdata};
          pop_done  = 1'b1;
        end
      end
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_50m or negedge rstn) begin
    if (!rstn) begin
      state_q   <= IDLE;
      rd_data_q <= '0;
    end else begin
      state_q   <= state_d;
      rd_data_q <= rd_data_d;
    end
  end

  always_ff @(posedge clk_50m or negedge rstn) begin
    if (!rstn) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else if (flush) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      if (push_ok)  wptr_q <= wptr_q + ADDR_W'(1);
      if (pop_done) rptr_q <= rptr_q + ADDR_W'(1);
      case ({push_ok, pop_done})
        2'b10:   count_q <= count_q + (ADDR_W+1)'(1);
        2'b01:   count_q <= count_q - (ADDR_W+1)'(1);
        default: count_q <= count_q;
      endcase
      // a drop in the same cycle as a status read keeps the flag set
      if (push_drop)    ovf_q <= 1'b1;
      else if (ovf_clr) ovf_q <= 1'b0;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_key_fifo_ctrl.sv
// ============================================================================
// tb_key_fifo_ctrl : directed self-checking bench, ADDR_W = 3, with RAM model
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_key_fifo_ctrl;

  localparam int AW = 3;
  localparam int DW = 8;

  logic          clk_50m = 1'b0;
  logic          rstn;
  logic          push_valid;
  logic [DW-1:0] push_data;
  logic          flush;
  logic          rd_req;
  logic          rd_sel;
  logic          rd_ack;
  logic [31:0]   rd_data;
  logic          ram_we;
  logic [AW-1:0] ram_waddr;
  logic [DW-1:0] ram_wdata;
  logic [AW-1:0] ram_raddr;
  logic [DW-1:0] ram_rdata;
  logic          full;
  logic          empty;
  logic          overflow;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] mem [2**AW];

  always #10 clk_50m = ~clk_50m;

  always @(posedge clk_50m) begin
    if (ram_we) mem[ram_waddr] <= ram_wdata;
    ram_rdata <= mem[ram_raddr];
  end

  key_fifo_ctrl #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk_50m    (clk_50m),
    .rstn       (rstn),
    .push_valid (push_valid),
    .push_data  (push_data),
    .flush      (flush),
    .rd_req     (rd_req),
    .rd_sel     (rd_sel),
    .rd_ack     (rd_ack),
    .rd_data    (rd_data),
    .ram_we     (ram_we),
    .ram_waddr  (ram_waddr),
    .ram_wdata  (ram_wdata),
    .ram_raddr  (ram_raddr),
    .ram_rdata  (ram_rdata),
    .full       (full),
    .empty      (empty),
    .overflow   (overflow)
  );

  task automatic tick();
    @(posedge clk_50m);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic do_push(input logic [DW-1:0] d, input logic exp_we, input logic [AW-1:0] exp_addr);
    push_valid = 1'b1;
    push_data  = d;
    #1;
    check("push_we", 32'(ram_we), 32'(exp_we));
    if (exp_we) check("push_waddr", 32'(ram_waddr), 32'(exp_addr));
    tick();
    push_valid = 1'b0;
  endtask

  // issue a read, wait a bounded number of cycles for rd_ack, check latency and data
  task automatic do_read(input string tag, input logic sel, input int exp_lat, input logic [31:0] exp_data);
    int lat;
    rd_req = 1'b1;
    rd_sel = sel;
    tick();
    rd_req = 1'b0;
    lat = 1;
    while (!rd_ack && lat < 6) begin
      tick();
      lat++;
    end
    check({tag, "_ack"}, 32'(rd_ack), 32'd1);
    check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    check({tag, "_data"}, rd_data, exp_data);
    tick();
    check({tag, "_ackpulse"}, 32'(rd_ack), 32'd0);
  endtask

  initial begin
    rstn = 1'b0; push_valid = 1'b0; push_data = '0; flush = 1'b0;
    rd_req = 1'b0; rd_sel = 1'b0;
    for (int i = 0; i < 2**AW; i++) mem[i] = '0;
    tick(); tick();
    check("rst_empty", 32'(empty), 32'd1);
    check("rst_full", 32'(full), 32'd0);
    check("rst_ovf", 32'(overflow), 32'd0);
    check("rst_ack", 32'(rd_ack), 32'd0);
    check("rst_rdata", rd_data, 32'd0);
    check("rst_we", 32'(ram_we), 32'd0);
    rstn = 1'b1;
    tick();

    do_read("stat0", 1'b1, 1, 32'h0001_0000);

    do_push(8'h41, 1'b1, 3'd0);
    do_push(8'h42, 1'b1, 3'd1);
    do_read("pop41", 1'b0, 2, 32'h41);
    do_read("pop42", 1'b0, 2, 32'h42);
    do_read("stat1", 1'b1, 1, 32'h0001_0000);

    do_read("pop_empty", 1'b0, 1, 32'h0);
    check("pop_empty_rptr", 32'(ram_raddr), 32'd2);
    do_read("stat2", 1'b1, 1, 32'h0001_0000);

    flush = 1'b1; tick(); flush = 1'b0;
    for (int i = 0; i < 8; i++) do_push(8'h10 + 8'(i), 1'b1, 3'(i));
    check("full_after8", 32'(full), 32'd1);
    check("ovf_before9", 32'(overflow), 32'd0);
    do_push(8'hEE, 1'b0, 3'd0);
    check("ovf_after9", 32'(overflow), 32'd1);
    do_read("stat_ovf", 1'b1, 1, 32'h8002_0008);
    do_read("stat_ovfclr", 1'b1, 1, 32'h0002_0008);

    do_read("wpop0", 1'b0, 2, 32'h10);
    do_read("wpop1", 1'b0, 2, 32'h11);
    do_read("wpop2", 1'b0, 2, 32'h12);
    for (int i = 0; i < 3; i++) do_push(8'h20 + 8'(i), 1'b1, 3'(i));
    check("wrap_waddr", 32'(ram_waddr), 32'd3);
    do_read("stat_wrap", 1'b1, 1, 32'h0002_0008);
    for (int i = 0; i < 5; i++) do_read("wpop_a", 1'b0, 2, 32'h13 + 32'(i));
    for (int i = 0; i < 3; i++) do_read("wpop_b", 1'b0, 2, 32'h20 + 32'(i));
    do_read("stat_drained", 1'b1, 1, 32'h0001_0000);

    // push lands during the WAIT cycle of a pop
    do_push(8'h55, 1'b1, 3'd3);
    rd_req = 1'b1; rd_sel = 1'b0;
    tick();
    rd_req = 1'b0;
    push_valid = 1'b1; push_data = 8'h66;
    tick();
    push_valid = 1'b0;
    check("pp_ack", 32'(rd_ack), 32'd1);
    check("pp_data", rd_data, 32'h55);
    tick();
    do_read("stat_pp", 1'b1, 1, 32'h0000_0001);

    // flush while the pop is in WAIT
    rd_req = 1'b1; rd_sel = 1'b0;
    tick();
    rd_req = 1'b0;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("fl_ack", 32'(rd_ack), 32'd1);
    check("fl_data", rd_data, 32'h0);
    tick();
    check("fl_raddr", 32'(ram_raddr), 32'd0);
    do_read("stat_fl", 1'b1, 1, 32'h0001_0000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
